// File: rtl/oci_trace_pkg.sv
// Shared types and constants for the OCI trace monitor: FSM state encoding and
// counter saturation limits.
package oci_trace_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        StCapture = 2'd0,
        StDrain   = 2'd1,
        StDone    = 2'd2,
        StError   = 2'd3
    } state_e;

    localparam logic [15:0] FRAME_SAT = 16'hFFFF;
    localparam logic [7:0]  DROP_SAT  = 8'hFF;

endpackage

// File: rtl/oci_trace_fifo.sv
// Synchronous FIFO with extra-MSB pointers; the head entry is presented straight from the
// storage registers and reads as zero while empty.
module oci_trace_fifo #(
    parameter int unsigned WIDTH = 30,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           rdata_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              push_ok;
    logic              pop_ok;

    always_comb begin
        empty_o = (wptr_q == rptr_q);
        full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        count_o = wptr_q - rptr_q;
        pop_ok  = pop_i && !empty_o;
        // A pop frees the slot the push lands in, so full + pop still accepts.
        push_ok = push_i && (!full_o || pop_ok);
        wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop_ok  ? rptr_q + 1'b1 : rptr_q;
        valid_o = !empty_o;
        rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/oci_trace_monitor.sv
// OCI debug-trace capture monitor: commit detect, frame FIFO, counters and test-end FSM.
// Optional stored even parity per entry when OCI_TRACE_PARITY_EN is defined.
module oci_trace_monitor
    import oci_trace_pkg::*;
#(
    parameter int unsigned DATA_W    = 30,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned FRAME_CNT = 15,
    parameter int unsigned DEPTH     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  dct_buffer,
    input  logic [CNT_W-1:0]   dct_count,
    input  logic               test_ending,
    input  logic               test_has_ended,
    input  logic               rd_ready,
    output logic               rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_parity_err,
    output logic [15:0]        frame_count,
    output logic [7:0]         drop_count,
    output logic               overflow,
    output logic               late_frame,
    output logic [STATE_W-1:0] state,
    output logic               done,
    output logic               error
);

    localparam int unsigned AW = $clog2(DEPTH);
`ifdef OCI_TRACE_PARITY_EN
    localparam int unsigned FIFO_W = DATA_W + 1;
`else
    localparam int unsigned FIFO_W = DATA_W;
`endif

    state_e      state_q, state_d;
    logic        match_q, match_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic [7:0]  drop_count_q, drop_count_d;
    logic        overflow_q, overflow_d;
    logic        late_frame_q, late_frame_d;

    logic              commit, capture, push, pop, drop, empty_after_pop;
    logic              fifo_full, fifo_empty, fifo_valid;
    logic [AW:0]       fifo_count;
    logic [FIFO_W-1:0] fifo_wdata, fifo_rdata;

    always_comb begin
        match_d = (dct_count == CNT_W'(FRAME_CNT));
        commit  = match_d && !match_q;
        capture = (state_q == StCapture);
        push    = commit && capture;
        pop     = fifo_valid && rd_ready;
        drop    = push && fifo_full && !pop;
        empty_after_pop = fifo_empty || ((fifo_count == {{AW{1'b0}}, 1'b1}) && pop);
    end

`ifdef OCI_TRACE_PARITY_EN
    assign fifo_wdata    = {^dct_buffer, dct_buffer};
    assign rd_parity_err = fifo_valid && (fifo_rdata[DATA_W] != ^fifo_rdata[DATA_W-1:0]);
`else
    assign fifo_wdata    = dct_buffer;
    assign rd_parity_err = 1'b0;
`endif

    oci_trace_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .valid_o (fifo_valid),
        .rdata_o (fifo_rdata)
    );

    always_comb begin
        state_d       = state_q;
        frame_count_d = frame_count_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q;
        late_frame_d  = late_frame_q;

        if (push && (frame_count_q != FRAME_SAT)) frame_count_d = frame_count_q + 16'd1;
        if (drop && (drop_count_q != DROP_SAT))   drop_count_d  = drop_count_q + 8'd1;
        if (drop)                                 overflow_d    = 1'b1;
        if (commit && !capture)                   late_frame_d  = 1'b1;

        unique case (state_q)
            StCapture: begin
                // A same-cycle push leaves an entry behind, so it counts as not drained.
                if (test_has_ended) state_d = (empty_after_pop && !push) ? StDone : StError;
                else if (test_ending) state_d = StDrain;
            end
            StDrain: begin
                if (test_has_ended) state_d = empty_after_pop ? StDone : StError;
            end
            StDone:  state_d = StDone;
            StError: state_d = StError;
            default: state_d = StCapture;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StCapture;
            match_q       <= 1'b0;
            frame_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
            late_frame_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            match_q       <= match_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
            late_frame_q  <= late_frame_d;
        end
    end

    assign rd_valid    = fifo_valid;
    assign rd_data     = fifo_rdata[DATA_W-1:0];
    assign frame_count = frame_count_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;
    assign late_frame  = late_frame_q;
    assign state       = state_q;
    assign done        = (state_q == StDone);
    assign error       = (state_q == StError);

endmodule

// File: tb/tb_oci_trace_monitor.sv
// Directed bench for oci_trace_monitor with a queue scoreboard of expected drain data.
// Parity-flip step is compiled only with OCI_TRACE_PARITY_EN.
module tb_oci_trace_monitor;

    localparam int unsigned DATA_W = 30;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] dct_buffer = '0;
    logic [CNT_W-1:0]  dct_count = '0;
    logic              test_ending = 1'b0;
    logic              test_has_ended = 1'b0;
    logic              rd_ready = 1'b0;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_parity_err;
    logic [15:0]       frame_count;
    logic [7:0]        drop_count;
    logic              overflow;
    logic              late_frame;
    logic [1:0]        state;
    logic              done;
    logic              error;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [DATA_W-1:0] exp_q[$];
    int unsigned       n;

    oci_trace_monitor #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .FRAME_CNT (15),
        .DEPTH     (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_parity_err  (rd_parity_err),
        .frame_count    (frame_count),
        .drop_count     (drop_count),
        .overflow       (overflow),
        .late_frame     (late_frame),
        .state          (state),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Two-cycle frame: count hits 15 for one cycle, then clears.
    task automatic commit_frame(input logic [DATA_W-1:0] data, input bool_store);
        dct_buffer = data;
        dct_count  = 4'd15;
        step();
        dct_count  = 4'd0;
        step();
        if (bool_store) exp_q.push_back(data);
    endtask

    // Pops until empty, comparing against the scoreboard; returns entries drained.
    task automatic drain(input string tag, output int unsigned cnt);
        logic [DATA_W-1:0] e;
        cnt = 0;
        rd_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!rd_valid) break;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
            check(tag, 32'(rd_data), 32'(e));
            cnt++;
            step();
        end
        rd_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_data"}, 32'(rd_data), 32'd0);
        check({tag, "_perr"}, 32'(rd_parity_err), 32'd0);
        check({tag, "_fc"}, 32'(frame_count), 32'd0);
        check({tag, "_dc"}, 32'(drop_count), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_late"}, 32'(late_frame), 32'd0);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(error), 32'd0);
    endtask

    initial begin
        logic [DATA_W-1:0] x;
        step();
        step();
        reset = 1'b0;
        check_reset_vals("rst");

        // Held count gives exactly one frame, visible one cycle after the event.
        dct_buffer = 30'h1234567;
        dct_count  = 4'd15;
        step();
        exp_q.push_back(30'h1234567);
        check("lat_valid", 32'(rd_valid), 32'd1);
        check("lat_data", 32'(rd_data), 32'h1234567);
        for (int i = 0; i < 4; i++) step();
        dct_count = 4'd0;
        step();
        check("fc_one", 32'(frame_count), 32'd1);
        drain("one_data", n);
        check("one_entries", n, 32'd1);

        // 18 commits into a 16-deep FIFO with no reads.
        for (int i = 0; i < 18; i++) commit_frame(30'h100 + 30'(i), (i < 16));
        check("ovf_dc", 32'(drop_count), 32'd2);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_valid", 32'(rd_valid), 32'd1);

        // Full with a simultaneous pop and push: nothing dropped.
        x = 30'h2AAAAAA;
        check("fullpp_head", 32'(rd_data), 32'(exp_q.pop_front()));
        rd_ready   = 1'b1;
        dct_buffer = x;
        dct_count  = 4'd15;
        step();
        rd_ready   = 1'b0;
        dct_count  = 4'd0;
        step();
        exp_q.push_back(x);
        check("fullpp_dc", 32'(drop_count), 32'd2);
        drain("order", n);
        check("order_entries", n, 32'd16);
        check("order_sb_empty", exp_q.size(), 32'd0);

        // Drain phase: commits are late and not counted.
        test_ending = 1'b1;
        step();
        check("drain_state", 32'(state), 32'd1);
        commit_frame(30'h3333, 1'b0);
        check("late_flag", 32'(late_frame), 32'd1);
        check("late_fc", 32'(frame_count), 32'd20);
        check("late_valid", 32'(rd_valid), 32'd0);
        test_has_ended = 1'b1;
        step();
        check("done_flag", 32'(done), 32'd1);
        check("done_err", 32'(error), 32'd0);
        check("done_state", 32'(state), 32'd2);
        test_ending    = 1'b0;
        test_has_ended = 1'b0;

        // Unclean end with 3 queued, then reset mid-drain.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) commit_frame(30'h500 + 30'(i), 1'b1);
        test_has_ended = 1'b1;
        step();
        test_has_ended = 1'b0;
        check("err_flag", 32'(error), 32'd1);
        check("err_state", 32'(state), 32'd3);
        check("err_head", 32'(rd_data), 32'h500);
        rd_ready = 1'b1;
        step();
        check("err_pop", 32'(rd_data), 32'h501);
        rd_ready = 1'b0;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        exp_q.delete();
        check_reset_vals("midrst");

        commit_frame(30'h0ABCDEF, 1'b1);
        commit_frame(30'h0123456, 1'b1);
`ifdef OCI_TRACE_PARITY_EN
        dut.u_fifo.mem_q[0][0] = ~dut.u_fifo.mem_q[0][0];
        #1;
        check("par_bad", 32'(rd_parity_err), 32'd1);
        void'(exp_q.pop_front());
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        check("par_next", 32'(rd_parity_err), 32'd0);
        check("par_next_data", 32'(rd_data), 32'(exp_q.pop_front()));
`else
        check("par_off", 32'(rd_parity_err), 32'd0);
        drain("par_off_data", n);
        check("par_off_entries", n, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
